riscv_mem_arbiter: RTL and testbench

Shares one single-ported memory/bus slave between the RV32I core's instruction-fetch port and data (load/store) port. It registers each request, drives one outstanding access at a time on the memory side, and returns a one-cycle done pulse with read data or an error to the winning requester. Ties are broken round-robin. Illegal accesses and non-responding slaves are terminated with an error, so the core never hangs.

---
 rtl/riscv_bus_pkg.sv | 24 ++
 rtl/riscv_rr_arb2.sv | 27 ++
 rtl/riscv_mem_arbiter.sv | 106 ++++++++++
 tb/tb_riscv_mem_arbiter.sv | 414 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bus_pkg.sv
// riscv_bus_pkg: shared encodings and byte-enable legality for the core memory arbiter
package riscv_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef enum logic {GNT_FETCH, GNT_DATA} gnt_t;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_W    = 4'b1111;

  // Single bytes go anywhere; halves must sit on their own half-word; words must be aligned.
  function automatic logic be_legal(input logic [1:0] a, input logic [3:0] we);
    return (we == BE_NONE) || (we == BE_B0) || (we == BE_B1) || (we == BE_B2) || (we == BE_B3) ||
           ((we == BE_H0) && (a == 2'b00)) || ((we == BE_H1) && (a == 2'b10)) ||
           ((we == BE_W) && (a == 2'b00));
  endfunction

endpackage

// File: rtl/riscv_rr_arb2.sv
// riscv_rr_arb2: two-way round-robin picker; only ties advance the rotation
module riscv_rr_arb2
  import riscv_bus_pkg::*;
(
  input  logic clk,
  input  logic clrn,
  input  logic req_fetch,
  input  logic req_data,
  input  logic upd,
  output logic gnt
);

  gnt_t last_gnt;

  // a lone request always wins; a tie goes to whoever lost the previous tie
  always_comb
    gnt = (req_fetch && req_data) ? ((last_gnt == GNT_FETCH) ? GNT_DATA : GNT_FETCH)
                                  : (req_data ? GNT_DATA : GNT_FETCH);

  // remember the tie winner so the next tie goes the other way
  always_ff @(posedge clk or negedge clrn)
    if (!clrn)
      last_gnt <= GNT_FETCH;
    else if (upd)
      last_gnt <= gnt_t'(gnt);

endmodule

// File: rtl/riscv_mem_arbiter.sv
// riscv_mem_arbiter: shares one single-ported memory slave between fetch and data ports
module riscv_mem_arbiter
  import riscv_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter int unsigned CNT_W       = 8
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_done,
  output logic [31:0] if_rdata,
  output logic        if_err,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [3:0]  d_we,
  input  logic [31:0] d_wdata,
  output logic        d_done,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic        m_req,
  output logic [31:0] m_addr,
  output logic [3:0]  m_we,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack
);

  state_t           state, state_nxt;
  gnt_t             gnt_q;
  logic             gnt, any_req, legal, timeout, resp;
  logic [31:0]      addr_q, wdata_q, rdata_q;
  logic [3:0]       we_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt;

  assign any_req = if_req || d_req;
  assign legal   = (gnt == GNT_DATA) ? be_legal(d_addr[1:0], d_we) : (if_addr[1:0] == 2'b00);
  assign timeout = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  riscv_rr_arb2 u_arb (
    .clk       (clk),
    .clrn      (clrn),
    .req_fetch (if_req),
    .req_data  (d_req),
    .upd       ((state == IDLE) && if_req && d_req),
    .gnt       (gnt)
  );

  // state register; reset drops m_req immediately even mid-access
  always_ff @(posedge clk or negedge clrn)
    if (!clrn)
      state <= IDLE;
    else
      state <= state_nxt;

  // illegal requests skip the bus and answer straight away
  always_comb begin
    state_nxt = state;
    state_nxt = (state == IDLE)   ? (any_req ? (legal ? ACCESS : RESP) : IDLE) :
                (state == ACCESS) ? ((m_ack || timeout) ? RESP : ACCESS) : IDLE;
  end

  // latch the granted request, then record the slave's outcome when the access ends
  always_ff @(posedge clk or negedge clrn)
    if (!clrn) begin
      gnt_q   <= GNT_FETCH;
      addr_q  <= '0;
      we_q    <= BE_NONE;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      cnt     <= '0;
    end else if (state == IDLE && any_req) begin
      gnt_q   <= gnt_t'(gnt);
      addr_q  <= {((gnt == GNT_DATA) ? d_addr[31:2] : if_addr[31:2]), 2'b00};
      we_q    <= (gnt == GNT_DATA) ? d_we : BE_NONE;
      wdata_q <= (gnt == GNT_DATA) ? d_wdata : '0;
      rdata_q <= '0;
      err_q   <= !legal;
      cnt     <= '0;
    end else if (state == ACCESS) begin
      if (m_ack) begin
        rdata_q <= (we_q == BE_NONE) ? m_rdata : '0;
        err_q   <= 1'b0;
      end else if (timeout) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end else
        cnt <= cnt + CNT_W'(1);
    end

  assign resp     = (state == RESP);
  assign m_req    = (state == ACCESS);
  assign m_addr   = addr_q;
  assign m_we     = we_q;
  assign m_wdata  = wdata_q;
  assign if_done  = resp && (gnt_q == GNT_FETCH);
  assign if_err   = if_done && err_q;
  assign if_rdata = if_done ? rdata_q : '0;
  assign d_done   = resp && (gnt_q == GNT_DATA);
  assign d_err    = d_done && err_q;
  assign d_rdata  = d_done ? rdata_q : '0;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb_riscv_mem_arbiter: directed and randomized checks of the fetch/data memory arbiter
module tb_riscv_mem_arbiter;

  localparam int TO = 6;

  logic        clk = 0, clrn = 0;
  logic        if_req = 0, d_req = 0, m_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_rdata = 0;
  logic [3:0]  d_we = 0;
  logic        if_done, if_err, d_done, d_err, m_req;
  logic [31:0] if_rdata, d_rdata, m_addr, m_wdata;
  logic [3:0]  m_we;

  int n_tests = 0, n_fail = 0;

  riscv_mem_arbiter #(.TIMEOUT_CYC(TO), .CNT_W(8)) dut (
    .clk(clk), .clrn(clrn),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata), .if_err(if_err),
    .d_req(d_req), .d_addr(d_addr), .d_we(d_we), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
    .m_req(m_req), .m_addr(m_addr), .m_we(m_we), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- slave memory and reference memory ----------------
  logic [31:0] mem     [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];

  function automatic logic [31:0] init_word(logic [29:0] w);
    return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5AC3C3;
  endfunction

  function automatic logic [31:0] ref_rd(logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : init_word(a[31:2]);
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    logic [31:0] m;
    m = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
    ref_mem[a[31:2]] = (ref_rd(a) & ~m) | (d & m);
  endtask

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    mem[a[31:2]] = v;
    ref_mem[a[31:2]] = v;
  endtask

  int          slave_wait = 0, wcnt = 0, cur_len = 0, last_len = 0, acc_cnt = 0;
  bit          slave_mute = 0, rand_wait = 0, late_ack = 0, unstable = 0;
  logic [31:0] a0 = 0, d0 = 0, acc_addr = 0, acc_wdata = 0;
  logic [3:0]  w0 = 0, acc_we = 0;

  initial forever begin
    @(negedge clk);
    if (m_req) begin
      if (cur_len == 0) begin a0 = m_addr; w0 = m_we; d0 = m_wdata; end
      else if ({m_addr, m_we, m_wdata} !== {a0, w0, d0}) unstable = 1;
      cur_len++;
    end else begin
      if (cur_len != 0) last_len = cur_len;
      cur_len = 0;
    end
    m_ack = late_ack;
    m_rdata = $urandom;
    if (!m_req || slave_mute) wcnt = 0;
    else if (wcnt < slave_wait) wcnt++;
    else begin
      m_ack = 1;
      wcnt = 0;
      acc_cnt++;
      acc_addr = m_addr; acc_we = m_we; acc_wdata = m_wdata;
      if (m_we == 4'b0000)
        m_rdata = mem.exists(m_addr[31:2]) ? mem[m_addr[31:2]] : init_word(m_addr[31:2]);
      else begin
        logic [31:0] v;
        v = mem.exists(m_addr[31:2]) ? mem[m_addr[31:2]] : init_word(m_addr[31:2]);
        for (int b = 0; b < 4; b++) if (m_we[b]) v[8*b +: 8] = m_wdata[8*b +: 8];
        mem[m_addr[31:2]] = v;
      end
      if (rand_wait) slave_wait = $urandom_range(0, 3);
    end
  end

  // legality written from the access-size rules
  function automatic bit d_legal(logic [31:0] a, logic [3:0] we);
    if ($countones(we) <= 1) return 1;
    if (we == 4'b0011) return a[1:0] == 2'd0;
    if (we == 4'b1100) return a[1:0] == 2'd2;
    if (we == 4'b1111) return a[1:0] == 2'd0;
    return 0;
  endfunction

  task automatic do_reset;
    clrn = 0;
    @(negedge clk);
    clrn = 1;
  endtask

  // ---------------- directed tests ----------------
  task automatic test_reset;
    clrn = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({if_done, if_err, d_done, d_err, m_req} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctrl got %b want 00000", {if_done, if_err, d_done, d_err, m_req});
    end
    n_tests++;
    if ({if_rdata, d_rdata, m_addr, m_we, m_wdata} !== 132'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h %h %h want all 0", if_rdata, d_rdata, m_addr, m_we, m_wdata);
    end
    clrn = 1;
    @(negedge clk);
    n_tests++;
    if ({if_done, d_done, m_req} !== 3'b0) begin
      n_fail++; $display("FAIL reset_idle got %b want 000", {if_done, d_done, m_req});
    end
  endtask

  task automatic test_single_fetch;
    preload(32'h100, 32'h00000013);
    slave_wait = 0;
    if_addr = 32'h100; if_req = 1;
    @(negedge clk);
    n_tests++;
    if ({m_req, m_addr, m_we, if_done} !== {1'b1, 32'h100, 4'h0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_c1 got m_req=%b m_addr=%h m_we=%h done=%b want 1 100 0 0", m_req, m_addr, m_we, if_done);
    end
    @(negedge clk);
    n_tests++;
    if ({if_done, if_rdata, if_err, d_done, m_req} !== {1'b1, 32'h13, 1'b0, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL fetch_c2 got done=%b rdata=%h err=%b d_done=%b m_req=%b want 1 00000013 0 0 0", if_done, if_rdata, if_err, d_done, m_req);
    end
    if_req = 0;
    @(negedge clk);
    n_tests++;
    if (if_done !== 1'b0) begin n_fail++; $display("FAIL fetch_c3 got done=%b want 0", if_done); end
  endtask

  task automatic test_tie;
    logic [31:0] exp_f, exp_w;
    do_reset();
    ref_wr(32'h1002, 4'b1100, 32'hABCD0000);
    exp_w = ref_rd(32'h1000);
    exp_f = ref_rd(32'h200);
    if_addr = 32'h200; if_req = 1;
    d_addr = 32'h1002; d_we = 4'b1100; d_wdata = 32'hABCD0000; d_req = 1;
    @(negedge clk);
    n_tests++;
    if ({m_req, m_addr, m_we, m_wdata} !== {1'b1, 32'h1000, 4'hC, 32'hABCD0000}) begin
      n_fail++; $display("FAIL tie1_data_first got m_req=%b addr=%h we=%h wdata=%h want 1 1000 c abcd0000", m_req, m_addr, m_we, m_wdata);
    end
    @(negedge clk);
    n_tests++;
    if ({d_done, d_err, d_rdata, if_done} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL tie1_d_done got done=%b err=%b rdata=%h if_done=%b want 1 0 0 0", d_done, d_err, d_rdata, if_done);
    end
    d_req = 0;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({m_req, m_addr, m_we} !== {1'b1, 32'h200, 4'h0}) begin
      n_fail++; $display("FAIL tie1_fetch_second got m_req=%b addr=%h we=%h want 1 200 0", m_req, m_addr, m_we);
    end
    @(negedge clk);
    n_tests++;
    if ({if_done, if_err, if_rdata, d_done} !== {1'b1, 1'b0, exp_f, 1'b0}) begin
      n_fail++; $display("FAIL tie1_if_done got done=%b err=%b rdata=%h want 1 0 %h", if_done, if_err, if_rdata, exp_f);
    end
    if_req = 0;
    @(negedge clk);
    if_addr = 32'h204; if_req = 1;
    d_addr = 32'h1000; d_we = 4'b0000; d_req = 1;
    exp_f = ref_rd(32'h204);
    @(negedge clk);
    n_tests++;
    if ({m_req, m_addr} !== {1'b1, 32'h204}) begin
      n_fail++; $display("FAIL tie2_fetch_first got m_req=%b addr=%h want 1 204", m_req, m_addr);
    end
    @(negedge clk);
    n_tests++;
    if ({if_done, if_rdata} !== {1'b1, exp_f}) begin
      n_fail++; $display("FAIL tie2_if_done got done=%b rdata=%h want 1 %h", if_done, if_rdata, exp_f);
    end
    if_req = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({d_done, d_err, d_rdata} !== {1'b1, 1'b0, exp_w}) begin
      n_fail++; $display("FAIL tie2_load_back got done=%b err=%b rdata=%h want 1 0 %h", d_done, d_err, d_rdata, exp_w);
    end
    d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_wait_states;
    int c;
    preload(32'h2000, 32'hDEADBEEF);
    slave_wait = 5; unstable = 0;
    d_addr = 32'h2000; d_we = 0; d_req = 1;
    for (c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (d_done) break;
    end
    n_tests++;
    if (c !== 7) begin n_fail++; $display("FAIL wait_latency got %0d cycles want 7", c); end
    n_tests++;
    if ({d_rdata, d_err} !== {32'hDEADBEEF, 1'b0}) begin
      n_fail++; $display("FAIL wait_rdata got rdata=%h err=%b want deadbeef 0", d_rdata, d_err);
    end
    d_req = 0;
    @(negedge clk);
    n_tests++;
    if ({last_len, unstable} !== {32'd6, 1'b0}) begin
      n_fail++; $display("FAIL wait_m_req got len=%0d unstable=%b want 6 0", last_len, unstable);
    end
    slave_wait = 0;
  endtask

  task automatic test_illegal;
    logic [31:0] ad [3];
    logic [3:0]  we [3];
    int prev;
    prev = acc_cnt;
    if_addr = 32'h102; if_req = 1;
    @(negedge clk);
    n_tests++;
    if ({if_done, if_err, if_rdata, m_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL ill_fetch got done=%b err=%b rdata=%h m_req=%b want 1 1 0 0", if_done, if_err, if_rdata, m_req);
    end
    if_req = 0;
    @(negedge clk);
    ad[0] = 32'h3000; we[0] = 4'b0101;
    ad[1] = 32'h3001; we[1] = 4'b1111;
    ad[2] = 32'h3000; we[2] = 4'b1100;
    for (int i = 0; i < 3; i++) begin
      d_addr = ad[i]; d_we = we[i]; d_wdata = $urandom; d_req = 1;
      @(negedge clk);
      n_tests++;
      if ({d_done, d_err, d_rdata, m_req, if_done} !== {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
        n_fail++; $display("FAIL ill_data%0d got done=%b err=%b rdata=%h m_req=%b want 1 1 0 0", i, d_done, d_err, d_rdata, m_req);
      end
      d_req = 0;
      @(negedge clk);
    end
    n_tests++;
    if (acc_cnt !== prev) begin n_fail++; $display("FAIL ill_no_access got %0d accesses want 0", acc_cnt - prev); end
  endtask

  task automatic test_timeout;
    logic [31:0] exp_f;
    slave_mute = 1;
    d_addr = 32'h2000; d_we = 0; d_req = 1;
    @(negedge clk);
    n_tests++;
    if (m_req !== 1'b1) begin n_fail++; $display("FAIL to_start got m_req=%b want 1", m_req); end
    repeat (TO - 1) @(negedge clk);
    n_tests++;
    if ({m_req, d_done} !== 2'b10) begin n_fail++; $display("FAIL to_last got m_req=%b done=%b want 1 0", m_req, d_done); end
    #1 late_ack = 1;
    @(negedge clk);
    n_tests++;
    if ({d_done, d_err, d_rdata, m_req} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      n_fail++; $display("FAIL to_abort got done=%b err=%b rdata=%h m_req=%b want 1 1 0 0", d_done, d_err, d_rdata, m_req);
    end
    d_req = 0;
    #1 late_ack = 0;
    @(negedge clk);
    n_tests++;
    if ({last_len, d_done, if_done} !== {TO, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL to_len got len=%0d done=%b/%b want %0d 0/0", last_len, if_done, d_done, TO);
    end
    slave_mute = 0;
    exp_f = ref_rd(32'h300);
    if_addr = 32'h300; if_req = 1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({if_done, if_err, if_rdata, d_done} !== {1'b1, 1'b0, exp_f, 1'b0}) begin
      n_fail++; $display("FAIL to_recover got done=%b err=%b rdata=%h want 1 0 %h", if_done, if_err, if_rdata, exp_f);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_access;
    logic [31:0] exp_f, exp_d;
    slave_mute = 1;
    d_addr = 32'h2000; d_we = 0; d_req = 1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (m_req !== 1'b1) begin n_fail++; $display("FAIL mid_pre got m_req=%b want 1", m_req); end
    #2 clrn = 0;
    #1;
    n_tests++;
    if ({m_req, if_done, d_done, if_err, d_err} !== 5'b0) begin
      n_fail++; $display("FAIL mid_async got %b want 00000", {m_req, if_done, d_done, if_err, d_err});
    end
    exp_f = ref_rd(32'h400);
    exp_d = ref_rd(32'h1000);
    if_addr = 32'h400; if_req = 1;
    d_addr = 32'h1000; d_we = 0; d_req = 1;
    slave_mute = 0; slave_wait = 0;
    @(negedge clk);
    clrn = 1;
    @(negedge clk);
    n_tests++;
    if ({m_req, m_addr} !== {1'b1, 32'h1000}) begin
      n_fail++; $display("FAIL mid_data_first got m_req=%b addr=%h want 1 1000", m_req, m_addr);
    end
    @(negedge clk);
    n_tests++;
    if ({d_done, d_rdata} !== {1'b1, exp_d}) begin
      n_fail++; $display("FAIL mid_d_done got done=%b rdata=%h want 1 %h", d_done, d_rdata, exp_d);
    end
    d_req = 0;
    repeat (3) @(negedge clk);
    n_tests++;
    if ({if_done, if_rdata} !== {1'b1, exp_f}) begin
      n_fail++; $display("FAIL mid_if_done got done=%b rdata=%h want 1 %h", if_done, if_rdata, exp_f);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  // ---------------- randomized traffic against the reference memory ----------------
  task automatic test_random;
    bit          if_pend = 0, d_pend = 0;
    int          if_age = 0, d_age = 0, prev_acc;
    bit          ex_if_err = 0, ex_d_err = 0;
    logic [31:0] ex_if_rdata = 0, ex_d_rdata = 0, ex_if_addr = 0, ex_d_addr = 0, ex_d_wdata = 0;
    logic [3:0]  ex_d_we = 0;
    logic [3:0]  wl [12];
    wl = '{4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF, 4'hF, 4'h5, 4'h7};
    rand_wait = 1;
    slave_wait = $urandom_range(0, 3);
    prev_acc = acc_cnt;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (if_done && d_done) begin
        n_tests++; n_fail++; $display("FAIL rand_both_done at cycle %0d", c);
      end
      if (if_done) begin
        n_tests++;
        if (!if_pend || if_err !== ex_if_err || if_rdata !== ex_if_rdata ||
            acc_cnt !== prev_acc + (ex_if_err ? 0 : 1) ||
            (!ex_if_err && (acc_addr !== {ex_if_addr[31:2], 2'b00} || acc_we !== 4'h0))) begin
          n_fail++;
          $display("FAIL rand_fetch addr=%h got pend=%b err=%b rdata=%h acc=%0d m_addr=%h want err=%b rdata=%h acc=%0d",
                   ex_if_addr, if_pend, if_err, if_rdata, acc_cnt - prev_acc, acc_addr, ex_if_err, ex_if_rdata, ex_if_err ? 0 : 1);
        end
        prev_acc = acc_cnt; if_pend = 0; if_req = 0;
      end
      if (d_done) begin
        n_tests++;
        if (!d_pend || d_err !== ex_d_err || d_rdata !== ex_d_rdata ||
            acc_cnt !== prev_acc + (ex_d_err ? 0 : 1) ||
            (!ex_d_err && (acc_addr !== {ex_d_addr[31:2], 2'b00} || acc_we !== ex_d_we ||
                           (ex_d_we != 0 && acc_wdata !== ex_d_wdata)))) begin
          n_fail++;
          $display("FAIL rand_data addr=%h we=%h got pend=%b err=%b rdata=%h acc=%0d m_addr=%h m_we=%h want err=%b rdata=%h",
                   ex_d_addr, ex_d_we, d_pend, d_err, d_rdata, acc_cnt - prev_acc, acc_addr, acc_we, ex_d_err, ex_d_rdata);
        end
        prev_acc = acc_cnt; d_pend = 0; d_req = 0;
      end
      if (if_pend && ++if_age > 40) begin
        n_tests++; n_fail++; $display("FAIL rand_fetch_stall addr=%h waited %0d cycles", ex_if_addr, if_age);
        if_pend = 0; if_req = 0;
      end
      if (d_pend && ++d_age > 40) begin
        n_tests++; n_fail++; $display("FAIL rand_data_stall addr=%h waited %0d cycles", ex_d_addr, d_age);
        d_pend = 0; d_req = 0;
      end
      if (c < 600 && !if_pend && $urandom_range(0, 2) == 0) begin
        ex_if_addr = $urandom_range(0, 4095);
        if ($urandom_range(0, 3) != 0) ex_if_addr[1:0] = 2'b00;
        ex_if_err = ex_if_addr[1:0] != 2'b00;
        ex_if_rdata = ex_if_err ? 32'h0 : ref_rd(ex_if_addr);
        if_addr = ex_if_addr; if_req = 1; if_pend = 1; if_age = 0;
      end
      if (c < 600 && !d_pend && $urandom_range(0, 2) == 0) begin
        ex_d_addr = 32'h1000 | $urandom_range(0, 4095);
        ex_d_we = wl[$urandom_range(0, 11)];
        ex_d_wdata = $urandom;
        ex_d_err = !d_legal(ex_d_addr, ex_d_we);
        ex_d_rdata = (ex_d_err || ex_d_we != 0) ? 32'h0 : ref_rd(ex_d_addr);
        if (!ex_d_err && ex_d_we != 0) ref_wr(ex_d_addr, ex_d_we, ex_d_wdata);
        d_addr = ex_d_addr; d_we = ex_d_we; d_wdata = ex_d_wdata; d_req = 1; d_pend = 1; d_age = 0;
      end
    end
    n_tests++;
    if (if_pend || d_pend) begin n_fail++; $display("FAIL rand_drain got pending fetch=%b data=%b want 0 0", if_pend, d_pend); end
    rand_wait = 0;
    slave_wait = 0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_tie();
    test_wait_states();
    test_illegal();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
